// File: rtl/pid_mc_pkg.sv
// Shared types, constants and helpers for the multichannel PID controller.
package pid_mc_pkg;

    // One channel walks ERR -> MUL_P -> MUL_I -> MUL_D -> OUT.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MUL_P,
        S_MUL_I,
        S_MUL_D,
        S_OUT
    } state_t;

    // Direction in which a channel's command clipped on its last frame.
    typedef enum logic [1:0] {
        SAT_NONE,
        SAT_POS,
        SAT_NEG
    } sat_t;

    localparam int STAGES_PER_CH = 5;

    localparam logic [1:0] SEL_KP   = 2'd0;
    localparam logic [1:0] SEL_KI   = 2'd1;
    localparam logic [1:0] SEL_KD   = 2'd2;
    localparam logic [1:0] SEL_RSVD = 2'd3;

    // Clip x to a w-bit signed range; sym=1 keeps the range symmetric
    // (+/-(2^(w-1)-1)), sym=0 allows the extra negative code -2^(w-1).
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int w,
                                                      input logic sym);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = sym ? -hi : (-hi - 64'sd1);
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

endpackage

// File: rtl/pid_mc_datapath.sv
// Error/derivative/integrator stage, shared multiply-accumulate and output
// saturation for whichever channel the controller is currently serving.
module pid_mc_datapath
    import pid_mc_pkg::*;
#(
    parameter int DW    = 16,
    parameter int GW    = 8,
    parameter int IW    = 24,
    parameter int OW    = 12,
    parameter int SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  state_t               st_i,
    input  logic signed [DW-1:0] sp_i,
    input  logic signed [DW-1:0] fb_i,
    input  logic signed [DW:0]   eprev_i,
    input  logic signed [IW-1:0] integ_i,
    input  sat_t                 sat_i,
    input  logic [GW-1:0]        kp_i,
    input  logic [GW-1:0]        ki_i,
    input  logic [GW-1:0]        kd_i,
    output logic signed [DW:0]   e_o,
    output logic signed [IW-1:0] integ_o,
    output logic signed [OW-1:0] u_o,
    output sat_t                 sat_o
);

    localparam int AW = GW + IW + 2;
    localparam int BW = (IW > DW + 2) ? IW : DW + 2;
    localparam int PW = GW + 1 + BW;

    logic signed [DW:0]   e_d, e_q;
    logic signed [DW+1:0] d_d, d_q;
    logic signed [IW-1:0] inew_d, inew_q;
    logic signed [AW-1:0] acc_q;
    logic signed [63:0]   isum;
    logic                 hold;

    logic [GW-1:0]        gain;
    logic signed [BW-1:0] bop;
    logic signed [PW-1:0] prod;

    logic signed [AW-1:0] shifted;
    logic signed [63:0]   usat;

    // Error, derivative and clamped integrator with conditional anti-windup.
    always_comb begin
        e_d    = (DW+1)'(sp_i) - (DW+1)'(fb_i);
        d_d    = (DW+2)'(e_d) - (DW+2)'(eprev_i);
        isum   = sat_signed(64'(integ_i) + 64'(e_d), IW, 1'b1);
        hold   = ((sat_i == SAT_POS) && !e_d[DW] && (e_d != '0)) ||
                 ((sat_i == SAT_NEG) && e_d[DW]);
        inew_d = hold ? integ_i : IW'(isum);
    end

    // Shared multiplier operand select; gains are unsigned so zero-extend.
    always_comb begin
        gain = kp_i;
        bop  = BW'(e_q);
        case (st_i)
            S_MUL_I: begin gain = ki_i; bop = BW'(inew_q); end
            S_MUL_D: begin gain = kd_i; bop = BW'(d_q);    end
            default: ;
        endcase
        prod = PW'(signed'({1'b0, gain})) * PW'(bop);
    end

    // Latch the channel's terms in ERR, then accumulate one product per MUL state.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q    <= '0;
            d_q    <= '0;
            inew_q <= '0;
            acc_q  <= '0;
        end else begin
            case (st_i)
                S_ERR: begin
                    e_q    <= e_d;
                    d_q    <= d_d;
                    inew_q <= inew_d;
                    acc_q  <= '0;
                end
                S_MUL_P, S_MUL_I, S_MUL_D: acc_q <= acc_q + AW'(prod);
                default: ;
            endcase
        end
    end

    // Scale down (floor) and clip to the command range, reporting clip direction.
    always_comb begin
        shifted = acc_q >>> SHIFT;
        usat    = sat_signed(64'(shifted), OW, 1'b0);
        u_o     = OW'(usat);
        if (usat == 64'(shifted)) sat_o = SAT_NONE;
        else if (shifted[AW-1])   sat_o = SAT_NEG;
        else                      sat_o = SAT_POS;
    end

    assign e_o     = e_q;
    assign integ_o = inew_q;

endmodule

// File: rtl/pid_multichannel.sv
// Time-multiplexed PID controller: frame sequencer, gain RAM and per-channel
// state around a single shared multiply-accumulate datapath.
module pid_multichannel
    import pid_mc_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DW    = 16,
    parameter int GW    = 8,
    parameter int IW    = 24,
    parameter int OW    = 12,
    parameter int SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH*DW-1:0] sp,
    input  logic [NCH*DW-1:0] fb,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [1:0]        wr_sel,
    input  logic [GW-1:0]     wr_data,
    output logic [NCH*OW-1:0] u,
    output logic              u_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic           u_valid_q, u_valid_d;

    logic [GW-1:0]        kp_q [NCH];
    logic [GW-1:0]        ki_q [NCH];
    logic [GW-1:0]        kd_q [NCH];
    logic signed [IW-1:0] integ_q [NCH];
    logic signed [DW:0]   eprev_q [NCH];
    sat_t                 sat_q [NCH];
    logic signed [OW-1:0] u_q [NCH];

    logic                 wr_ok;
    logic [CW-1:0]        wr_idx;
    logic signed [DW:0]   dp_e;
    logic signed [IW-1:0] dp_integ;
    logic signed [OW-1:0] dp_u;
    sat_t                 dp_sat;

    assign busy    = (state_q != S_IDLE);
    assign overrun = sample_tick && busy;
    assign u_valid = u_valid_q;
    assign wr_ok   = wr_en && !busy && (int'(wr_ch) < NCH) && (wr_sel != SEL_RSVD);
    assign wr_idx  = wr_ch[CW-1:0];

    // Frame sequencing: five stages per channel, channels in ascending order.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        u_valid_d = 1'b0;
        case (state_q)
            S_IDLE:  if (sample_tick) begin state_d = S_ERR; ch_d = '0; end
            S_ERR:   state_d = S_MUL_P;
            S_MUL_P: state_d = S_MUL_I;
            S_MUL_I: state_d = S_MUL_D;
            S_MUL_D: state_d = S_OUT;
            S_OUT: begin
                if (ch_q == LAST_CH) begin
                    state_d   = S_IDLE;
                    u_valid_d = 1'b1;
                end else begin
                    state_d = S_ERR;
                    ch_d    = ch_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            u_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            u_valid_q <= u_valid_d;
        end
    end

    // Gain RAM: writes land only between frames so a frame sees consistent gains.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                kp_q[i] <= '0;
                ki_q[i] <= '0;
                kd_q[i] <= '0;
            end
        end else if (wr_ok) begin
            case (wr_sel)
                SEL_KP:  kp_q[wr_idx] <= wr_data;
                SEL_KI:  ki_q[wr_idx] <= wr_data;
                SEL_KD:  kd_q[wr_idx] <= wr_data;
                default: ;
            endcase
        end
    end

    // Commit a channel's results in OUT; a disabled channel is parked at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                integ_q[i] <= '0;
                eprev_q[i] <= '0;
                sat_q[i]   <= SAT_NONE;
                u_q[i]     <= '0;
            end
        end else if (state_q == S_OUT) begin
            if (ch_en[ch_q]) begin
                integ_q[ch_q] <= dp_integ;
                eprev_q[ch_q] <= dp_e;
                sat_q[ch_q]   <= dp_sat;
                u_q[ch_q]     <= dp_u;
            end else begin
                integ_q[ch_q] <= '0;
                eprev_q[ch_q] <= '0;
                sat_q[ch_q]   <= SAT_NONE;
                u_q[ch_q]     <= '0;
            end
        end
    end

    pid_mc_datapath #(
        .DW(DW), .GW(GW), .IW(IW), .OW(OW), .SHIFT(SHIFT)
    ) u_dp (
        .clk     (clk),
        .rst     (rst),
        .st_i    (state_q),
        .sp_i    (sp[int'(ch_q)*DW +: DW]),
        .fb_i    (fb[int'(ch_q)*DW +: DW]),
        .eprev_i (eprev_q[ch_q]),
        .integ_i (integ_q[ch_q]),
        .sat_i   (sat_q[ch_q]),
        .kp_i    (kp_q[ch_q]),
        .ki_i    (ki_q[ch_q]),
        .kd_i    (kd_q[ch_q]),
        .e_o     (dp_e),
        .integ_o (dp_integ),
        .u_o     (dp_u),
        .sat_o   (dp_sat)
    );

    for (genvar g = 0; g < NCH; g++) begin : g_u
        assign u[g*OW +: OW] = u_q[g];
    end

endmodule

// File: tb/tb_pid_multichannel.sv
// Directed bench for pid_multichannel with a frame-level behavioural model.
module tb_pid_multichannel;

    localparam int NCH = 4, DW = 16, GW = 8, IW = 24, OW = 12, SHIFT = 8;
    localparam longint IMAX = (longint'(1) << (IW - 1)) - 1;
    localparam longint UMAX = (longint'(1) << (OW - 1)) - 1;
    localparam longint UMIN = -UMAX - 1;
    localparam int FRAME = 5 * NCH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_tick = 1'b0;
    logic [NCH-1:0]    ch_en = '1;
    logic [NCH*DW-1:0] sp = '0;
    logic [NCH*DW-1:0] fb = '0;
    logic              wr_en = 1'b0;
    logic [2:0]        wr_ch = '0;
    logic [1:0]        wr_sel = '0;
    logic [GW-1:0]     wr_data = '0;
    logic [NCH*OW-1:0] u;
    logic              u_valid, busy, overrun;

    pid_multichannel #(
        .NCH(NCH), .DW(DW), .GW(GW), .IW(IW), .OW(OW), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .ch_en(ch_en),
        .sp(sp), .fb(fb), .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel),
        .wr_data(wr_data), .u(u), .u_valid(u_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic longint u_of(input int c);
        logic signed [OW-1:0] t;
        t = u[c*OW +: OW];
        return longint'(t);
    endfunction

    // ---------------- behavioural model ----------------
    longint mk [3][NCH];
    longint mI [NCH], mep [NCH], msat [NCH], mnu [NCH], exp_u [NCH];
    int     t0 = 0;
    bit     frame_on = 0;
    bit     chk_on = 0;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s < 3; s++) mk[s][c] = 0;
            mI[c] = 0; mep[c] = 0; msat[c] = 0; mnu[c] = 0; exp_u[c] = 0;
        end
        frame_on = 0;
    endtask

    // Whole-frame result for every channel, from the controller's rules.
    task automatic model_frame();
        for (int c = 0; c < NCH; c++) begin
            logic signed [DW-1:0] s, f;
            longint e, d, inew, acc, v;
            if (!ch_en[c]) begin
                mnu[c] = 0; mI[c] = 0; mep[c] = 0; msat[c] = 0;
            end else begin
                s = sp[c*DW +: DW];
                f = fb[c*DW +: DW];
                e = longint'(s) - longint'(f);
                d = e - mep[c];
                if ((msat[c] > 0 && e > 0) || (msat[c] < 0 && e < 0)) inew = mI[c];
                else begin
                    inew = mI[c] + e;
                    if (inew > IMAX) inew = IMAX;
                    if (inew < -IMAX) inew = -IMAX;
                end
                acc = mk[0][c] * e + mk[1][c] * inew + mk[2][c] * d;
                v = floor_div(acc, longint'(1) << SHIFT);
                msat[c] = 0;
                if (v > UMAX) begin v = UMAX; msat[c] = 1; end
                else if (v < UMIN) begin v = UMIN; msat[c] = -1; end
                mnu[c] = v; mI[c] = inew; mep[c] = e;
            end
        end
    endtask

    // Per-cycle compare against the model, then fold this cycle's inputs into it.
    always @(negedge clk) begin
        bit eb, ev;
        eb = 0;
        ev = 0;
        if (frame_on) begin
            for (int c = 0; c < NCH; c++)
                if (cyc == t0 + 5 * c + 6) exp_u[c] = mnu[c];
            eb = (cyc >= t0 + 1) && (cyc <= t0 + FRAME);
            ev = (cyc == t0 + FRAME + 1);
            if (cyc > t0 + FRAME) frame_on = 0;
        end
        if (chk_on) begin
            chk("busy", busy, eb);
            chk("u_valid", u_valid, ev);
            chk("overrun", overrun, sample_tick && eb);
            for (int c = 0; c < NCH; c++) chk($sformatf("u%0d", c), u_of(c), exp_u[c]);
        end
        if (rst) model_reset();
        else begin
            if (wr_en && !eb && (int'(wr_ch) < NCH) && (wr_sel != 2'd3))
                mk[wr_sel][wr_ch] = longint'(wr_data);
            if (sample_tick && !eb) begin
                model_frame();
                t0 = cyc;
                frame_on = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input int spv, input int fbv);
        sp[c*DW +: DW] = spv[DW-1:0];
        fb[c*DW +: DW] = fbv[DW-1:0];
    endtask

    task automatic wr_gain(input int c, input int sel, input int val);
        wr_en = 1'b1;
        wr_ch = c[2:0];
        wr_sel = sel[1:0];
        wr_data = val[GW-1:0];
        step();
        wr_en = 1'b0;
    endtask

    // Tick (optionally with a gain write in the same cycle), wait bounded for u_valid.
    task automatic do_frame(input bit with_wr);
        int ts, lat;
        ts = cyc;
        sample_tick = 1'b1;
        wr_en = with_wr;
        step();
        sample_tick = 1'b0;
        wr_en = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (u_valid) begin lat = cyc - ts; break; end
            step();
        end
        chk("latency", lat, FRAME + 1);
        step();
    endtask

    initial begin
        int ts;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1;
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_u_valid", u_valid, 0);
        for (int c = 0; c < NCH; c++) chk($sformatf("rst_u%0d", c), u_of(c), 0);

        // zero gains
        do_frame(0);
        for (int c = 0; c < NCH; c++) chk($sformatf("zero_u%0d", c), u_of(c), 0);

        wr_gain(0, 0, 16);
        wr_gain(1, 1, 32);
        wr_gain(2, 0, 255);
        wr_gain(2, 1, 1);
        wr_gain(3, 2, 64);
        wr_gain(5, 0, 99);   // out-of-range channel: dropped
        wr_gain(0, 3, 77);   // reserved select: dropped
        set_ch(0, 1000, 0);
        set_ch(1, 100, 0);
        set_ch(2, 20000, 0);
        set_ch(3, 0, 0);

        do_frame(0);
        chk("f1_u0", u_of(0), 62);
        chk("f1_u1", u_of(1), 12);
        chk("f1_u2", u_of(2), 2047);
        chk("f1_u3", u_of(3), 0);
        chk("f1_modelI1", mI[1], 100);
        chk("f1_modelI2", mI[2], 20000);

        set_ch(0, 1000, 2000);
        set_ch(3, 400, 0);
        do_frame(0);
        chk("f2_u0", u_of(0), -63);
        chk("f2_u1", u_of(1), 25);
        chk("f2_u2", u_of(2), 2047);
        chk("f2_u3", u_of(3), 100);
        chk("f2_modelI2", mI[2], 20000);

        do_frame(0);
        chk("f3_u1", u_of(1), 37);
        chk("f3_u2", u_of(2), 2047);
        chk("f3_u3", u_of(3), 0);
        chk("f3_modelI1", mI[1], 300);
        chk("f3_modelI2", mI[2], 20000);

        set_ch(2, -100, 0);
        set_ch(3, 800, 0);
        ch_en[3] = 1'b0;
        do_frame(0);
        chk("f4_u1", u_of(1), 50);
        chk("f4_u2", u_of(2), -22);
        chk("f4_u3", u_of(3), 0);
        chk("f4_modelI2", mI[2], 19900);

        // re-enable ch3; Kp1 written in the same cycle as the tick
        ch_en[3] = 1'b1;
        wr_ch = 3'd1; wr_sel = 2'd0; wr_data = 8'd64;
        do_frame(1);
        chk("f5_u1", u_of(1), 87);
        chk("f5_u2", u_of(2), -23);
        chk("f5_u3", u_of(3), 200);

        // overrun tick and a write while busy
        ts = cyc;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (4) step();
        wr_en = 1'b1; wr_ch = 3'd0; wr_sel = 2'd0; wr_data = 8'd100;
        step();
        wr_en = 1'b0;
        repeat (4) step();
        chk("ovr_at_T10", cyc - ts, 10);
        sample_tick = 1'b1;
        #1;
        chk("ovr_pulse", overrun, 1);
        step();
        sample_tick = 1'b0;
        for (int i = 0; i < 40 && !u_valid; i++) step();
        chk("ovr_done", u_valid, 1);
        repeat (25) step();
        chk("ovr_idle", busy, 0);
        chk("ovr_u0", u_of(0), -63);

        // reset in the middle of a frame
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_u_valid", u_valid, 0);
        for (int c = 0; c < NCH; c++) chk($sformatf("mrst_u%0d", c), u_of(c), 0);
        repeat (25) step();
        do_frame(0);
        for (int c = 0; c < NCH; c++) chk($sformatf("post_u%0d", c), u_of(c), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
